// File: rtl/i2c_pkg.sv
// Shared I2C target types: FSM states, R/W and ACK bit values.
// No logic; constants only.
// No flow control.
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RDATA_ACK
  } i2c_state_e;

  localparam logic I2C_RW_WRITE = 1'b0;
  localparam logic I2C_RW_READ  = 1'b1;
  localparam logic I2C_ACK      = 1'b0;
  localparam logic I2C_NACK     = 1'b1;

endpackage

// File: rtl/i2c_sync_edge.sv
// 2-FF synchronizer for an idle-high bus line, with rise/fall detect.
// Latency: 2 clk to q, edges flagged combinationally on q vs its previous value.
// No backpressure.
module i2c_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic q,
  output logic rise,
  output logic fall
);

  logic s1, s2, s3;

  // Reset to the bus idle level so releasing reset never fakes an edge on an idle bus.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      s3 <= 1'b1;
    end else begin
      s1 <= din;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign q    = s2;
  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;

endmodule

// File: rtl/i2c_slave_regs.sv
// I2C target bridging 8-bit pointer/data transactions onto a local register bank.
// Latency: SDA drive 3 clk after SCL fall; reg_wr 1 clk after 8th bit rise detect.
// No clock stretching: reg_rdata must be valid the cycle after reg_rd.
module i2c_slave_regs
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl,
  inout  wire        sda,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_wr,
  output logic       reg_rd,
  input  logic [7:0] reg_rdata,
  output logic       busy
);

  logic scl_q, scl_rise, scl_fall;
  logic sda_q, sda_rise, sda_fall;

  i2c_sync_edge u_scl (.clk(clk), .reset(reset), .din(scl), .q(scl_q), .rise(scl_rise), .fall(scl_fall));
  i2c_sync_edge u_sda (.clk(clk), .reset(reset), .din(sda), .q(sda_q), .rise(sda_rise), .fall(sda_fall));

  logic start_det, stop_det;
  assign start_det = sda_fall & scl_q;
  assign stop_det  = sda_rise & scl_q;

  i2c_state_e state, state_d;
  logic [2:0] bit_cnt, bit_cnt_d;
  logic [7:0] rx_sh, rx_sh_d, tx_sh, tx_sh_d, addr_d, wdata_d;
  logic       sda_low, sda_low_d, ack_on, ack_on_d, tx_first, tx_first_d;
  logic       rw, rw_d, busy_d, wr_d, rd_d, rd_load;
  logic [7:0] rx_byte;

  assign rx_byte = {rx_sh[6:0], sda_q};

  always_comb begin
    state_d    = state;
    bit_cnt_d  = bit_cnt;
    rx_sh_d    = rx_sh;
    tx_sh_d    = tx_sh;
    addr_d     = reg_addr;
    wdata_d    = reg_wdata;
    sda_low_d  = sda_low;
    ack_on_d   = ack_on;
    tx_first_d = tx_first;
    rw_d       = rw;
    busy_d     = busy;
    wr_d       = 1'b0;
    rd_d       = 1'b0;
    if (rd_load) tx_sh_d = reg_rdata;
    // Bus conditions override any bit edge seen in the same cycle.
    if (start_det) begin
      state_d   = ST_ADDR;
      bit_cnt_d = 3'd0;
      sda_low_d = 1'b0;
      ack_on_d  = 1'b0;
    end else if (stop_det) begin
      state_d   = ST_IDLE;
      sda_low_d = 1'b0;
      ack_on_d  = 1'b0;
      busy_d    = 1'b0;
    end else begin
      case (state)
        ST_ADDR, ST_PTR, ST_WDATA: begin
          if (scl_rise) begin
            rx_sh_d   = rx_byte;
            bit_cnt_d = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              if (state == ST_ADDR) begin
                if (rx_byte[7:1] == SLAVE_ADDR) begin
                  rw_d    = rx_byte[0];
                  busy_d  = 1'b1;
                  rd_d    = (rx_byte[0] == I2C_RW_READ);
                  state_d = ST_ADDR_ACK;
                end else begin
                  busy_d  = 1'b0;
                  state_d = ST_IDLE;
                end
              end else if (state == ST_PTR) begin
                addr_d  = rx_byte;
                state_d = ST_PTR_ACK;
              end else begin
                wdata_d = rx_byte;
                wr_d    = 1'b1;
                state_d = ST_WDATA_ACK;
              end
            end
          end
        end
        ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
          // First fall ends bit 8 and starts the ACK; the second ends the ACK.
          if (scl_fall) begin
            if (!ack_on) begin
              ack_on_d  = 1'b1;
              sda_low_d = 1'b1;
            end else begin
              ack_on_d  = 1'b0;
              sda_low_d = 1'b0;
              bit_cnt_d = 3'd0;
              if (state == ST_ADDR_ACK) begin
                if (rw == I2C_RW_READ) begin
                  state_d    = ST_RDATA;
                  sda_low_d  = ~tx_sh[7];
                  tx_first_d = 1'b0;
                end else begin
                  state_d = ST_PTR;
                end
              end else if (state == ST_PTR_ACK) begin
                state_d = ST_WDATA;
              end else begin
                addr_d  = reg_addr + 8'd1;
                state_d = ST_WDATA;
              end
            end
          end
        end
        ST_RDATA: begin
          if (scl_fall) begin
            if (tx_first) begin
              sda_low_d  = ~tx_sh[7];
              tx_first_d = 1'b0;
            end else begin
              tx_sh_d   = {tx_sh[6:0], 1'b0};
              sda_low_d = ~tx_sh[6];
            end
          end else if (scl_rise) begin
            bit_cnt_d = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state_d = ST_RDATA_ACK;
          end
        end
        ST_RDATA_ACK: begin
          if (scl_fall) begin
            sda_low_d = 1'b0;
          end else if (scl_rise) begin
            if (sda_q == I2C_ACK) begin
              addr_d     = reg_addr + 8'd1;
              rd_d       = 1'b1;
              tx_first_d = 1'b1;
              bit_cnt_d  = 3'd0;
              state_d    = ST_RDATA;
            end else begin
              busy_d    = 1'b0;
              sda_low_d = 1'b0;
              state_d   = ST_IDLE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      bit_cnt   <= 3'd0;
      rx_sh     <= 8'd0;
      tx_sh     <= 8'd0;
      reg_addr  <= 8'd0;
      reg_wdata <= 8'd0;
      sda_low   <= 1'b0;
      ack_on    <= 1'b0;
      tx_first  <= 1'b0;
      rw        <= I2C_RW_WRITE;
      busy      <= 1'b0;
      reg_wr    <= 1'b0;
      reg_rd    <= 1'b0;
      rd_load   <= 1'b0;
    end else begin
      state     <= state_d;
      bit_cnt   <= bit_cnt_d;
      rx_sh     <= rx_sh_d;
      tx_sh     <= tx_sh_d;
      reg_addr  <= addr_d;
      reg_wdata <= wdata_d;
      sda_low   <= sda_low_d;
      ack_on    <= ack_on_d;
      tx_first  <= tx_first_d;
      rw        <= rw_d;
      busy      <= busy_d;
      reg_wr    <= wr_d;
      reg_rd    <= rd_d;
      rd_load   <= reg_rd;
    end
  end

  assign sda = sda_low ? 1'b0 : 1'bz;

endmodule

// File: doc/i2c_slave_regs.md
# i2c_slave_regs

I2C target (slave) with an 8-bit register-pointer protocol: the responder for the same write-pointer/write-data and write-pointer/repeated-start/read transactions our I2C master wrapper issues. Sits between the board I2C pins and a local register bank, turning bus transactions into single-cycle write strobes and read fetches in the `clk` domain. Used as the debug/config target so an external controller can program core registers.

## Interface
- `SLAVE_ADDR`, 7'h50, 7-bit address this target answers to.
- `clk`  in  1  system clock; must be ≥ 16× the SCL frequency.
- `reset`  in  1  asynchronous, active-low reset.
- `scl`  in  1  I2C clock; input only, no clock stretching.
- `sda`  inout  1  I2C data; open-drain, driven only to 0, otherwise `z`.
- `reg_addr`  out  8  current register pointer.
- `reg_wdata`  out  8  write data, valid while `reg_wr` is high.
- `reg_wr`  out  1  one-cycle write strobe.
- `reg_rd`  out  1  one-cycle fetch strobe; `reg_rdata` is sampled on the next cycle.
- `reg_rdata`  in  8  read data for `reg_addr`.
- `busy`  out  1  high from an addressed START until STOP, NACK or a mismatch.

## Operation
- `scl` and `sda` each pass through a 2-FF synchronizer.
- Edge detects run on the synchronized values.
- START: `sda` falls while `scl` is high. STOP: `sda` rises while `scl` is high.
- States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK.
- START (including repeated START) from any state goes to ADDR and clears the bit counter.
- STOP from any state goes to IDLE, releases `sda` and clears `busy`.
- Receive: bits are shifted MSB-first on each synchronized SCL rising edge. A 3-bit counter marks the 8th bit.
- ADDR, after 8 bits:
  - match with R/W=0 → ADDR_ACK, then PTR.
  - match with R/W=1 → ADDR_ACK, assert `reg_rd`, then RDATA.
  - mismatch → IDLE, with no ACK and no strobes.
- PTR: after 8 bits, the byte is loaded into `reg_addr` → PTR_ACK → WDATA.
- WDATA: after 8 bits, set `reg_wdata`, pulse `reg_wr` for one cycle → WDATA_ACK. Then increment `reg_addr` mod 256 and return to WDATA.
- RDATA: shift register loaded from `reg_rdata` one cycle after `reg_rd`. Bits are driven MSB-first.
- RDATA_ACK samples the master's ACK bit:
  - 0 → increment `reg_addr`, pulse `reg_rd`, back to RDATA.
  - 1 (NACK) → IDLE, bus released.
- ACK drive: `sda` is pulled low from the SCL falling edge that ends bit 8 until the next SCL falling edge.
- In RDATA, each data bit changes on an SCL falling edge.
- `reg_addr` persists across transactions; a read without a preceding pointer write uses the last pointer.

## Timing
- Reset values: `reg_addr`=0, `reg_wdata`=0, `reg_wr`=0, `reg_rd`=0, `busy`=0, `sda` released, state IDLE.
- Input latency: 2 `clk` from pin to synchronized value, plus 1 for edge detect.
- SDA drive changes 3 `clk` after the physical SCL falling edge. This is well inside tLOW at the minimum clock ratio.
- `reg_wr` asserts 1 cycle after the 8th data-bit rising edge is detected.
- `reg_rd` asserts 1 cycle after the ADDR_ACK or RDATA_ACK decision. `reg_rdata` is captured the following cycle, before the next SCL falling edge.
- Simultaneous START/STOP detect with a bit edge: START/STOP wins.
- Reset mid-transaction: `sda` is released immediately (asynchronous) and no strobe is emitted.

## Structure
- Shared package `i2c_pkg`:
  - state enum/localparams;
  - `I2C_RW_READ`/`I2C_RW_WRITE` constants;
  - ACK/NACK bit constants.
- One sub-module, `i2c_sync_edge`: 2-FF synchronizer plus rise/fall detect. Instantiated twice, for `scl` and `sda`.
- Tri-state is done at this level (`sda = sda_low ? 1'b0 : 1'bz`). No tri-states below.

## Test plan
- Write: START, 0xA0, ptr 0x12, data 0x5A, STOP → three ACKs; `reg_wr` pulses once with `reg_addr`=0x12, `reg_wdata`=0x5A; `reg_addr` ends at 0x13.
- Burst with wrap: ptr 0xFE, data 0x01, 0x02, 0x03 → writes to 0xFE, 0xFF, 0x00; `reg_addr` ends at 0x01.
- Read: START, 0xA0, ptr 0x20, Sr, 0xA1, bench `reg_rdata`=0xC3 then 0x3C, master ACK then NACK → SDA shows 0xC3 then 0x3C. Two `reg_rd` pulses at addresses 0x20 and 0x21, then IDLE.
- Mismatch: START, 0xB0, 0x00 → SDA never driven low; no `reg_wr`/`reg_rd`; `busy` stays 0.
- Abort: STOP after 4 bits of a data byte → no `reg_wr`; IDLE; `sda` released. A following write to 0x05 succeeds normally.
- Reset: assert `reset` during the PTR_ACK low phase → `sda` released within the same cycle; `reg_addr`=0 after release.
